// File: rtl/pad_bank_ctrl_if.sv
// Core-side bus of the pad bank: per-signal I/O data/enables plus the config write port.
// Signal names carry the direction as seen from the pad-bank controller.
interface pad_bank_ctrl_if #(
    parameter int NumPads = 72,
    parameter int NumIo   = 71
);
    localparam int AddrW = (NumPads > 1) ? $clog2(NumPads) : 1;

    logic [NumIo-1:0] io_out_i;
    logic [NumIo-1:0] io_oe_i;
    logic [NumIo-1:0] io_in_o;
    logic             cfg_req_i;
    logic [AddrW-1:0] cfg_addr_i;
    logic [6:0]       cfg_wdata_i;
    logic             cfg_gnt_o;
    logic             cfg_err_o;

    modport master (
        output io_out_i, io_oe_i, cfg_req_i, cfg_addr_i, cfg_wdata_i,
        input  io_in_o, cfg_gnt_o, cfg_err_o
    );

    modport slave (
        input  io_out_i, io_oe_i, cfg_req_i, cfg_addr_i, cfg_wdata_i,
        output io_in_o, cfg_gnt_o, cfg_err_o
    );
endinterface

// File: rtl/pad_bank_ctrl.sv
// Pad-bank controller: power-up sequencer, per-pad config registers (gnt +1 cycle), 2-flop input sync (+2 cycles).
// No backpressure, one config write per cycle. Define PAD_BANK_LOOPBACK_EN to add lpbk_i core-to-sync loopback.
module pad_bank_ctrl #(
    parameter int NumPads      = 72,
    parameter int NumIo        = 71,
    parameter int PwrupCycles  = 16,
    parameter int SettleCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef PAD_BANK_LOOPBACK_EN
    input  logic               lpbk_i,
`endif
    pad_bank_ctrl_if.slave     bus,
    output logic               ready_o,
    output logic [NumPads-1:0] dq,
    output logic [NumPads-1:0] enq,
    output logic [NumPads-1:0] enabq,
    input  logic [NumPads-1:0] outi,
    output logic [NumPads-1:0] drv0,
    output logic [NumPads-1:0] drv1,
    output logic [NumPads-1:0] drv2,
    output logic [NumPads-1:0] pd,
    output logic [NumPads-1:0] puq,
    output logic [NumPads-1:0] prg_slew,
    output logic [NumPads-1:0] ppen,
    output logic [NumPads-1:0] pwrup_pull_en,
    output logic [NumPads-1:0] pwrupzhl
);
    localparam int CntMax = (PwrupCycles > SettleCycles) ? PwrupCycles : SettleCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [6:0]         CfgRst    = 7'b001_0_0_0_0;
    localparam logic [NumPads-1:0] SpareMask = ~NumPads'({NumIo{1'b1}});

    typedef enum logic [1:0] {PWRUP_HOLD, CFG_APPLY, SETTLE, ACTIVE} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hold_zhl, pull_on, rx_off, cfg_vis, active;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PWRUP_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_zhl = 1'b0;
        pull_on  = 1'b0;
        rx_off   = 1'b0;
        cfg_vis  = 1'b1;
        active   = 1'b0;
        case (state_q)
            PWRUP_HOLD: begin
                hold_zhl = 1'b1;
                pull_on  = 1'b1;
                rx_off   = 1'b1;
                cfg_vis  = 1'b0;
                if (cnt_q == CntW'(PwrupCycles - 1)) begin
                    state_d = CFG_APPLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CFG_APPLY: begin
                pull_on = 1'b1;
                rx_off  = 1'b1;
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt_q == CntW'(SettleCycles - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: active = 1'b1;
            default: state_d = PWRUP_HOLD;
        endcase
    end

    assign ready_o = (state_q == ACTIVE);

    // Config registers: {drv[2:0], pd, pu, slew, ppen}; spares never store pull bits.
    logic [6:0] cfg_q [NumPads];
    logic       gnt_q, err_q;
    logic       addr_ok, addr_spare;
    logic [6:0] wdata_eff;

    assign addr_ok    = 32'(bus.cfg_addr_i) < NumPads;
    assign addr_spare = 32'(bus.cfg_addr_i) >= NumIo;
    assign wdata_eff  = addr_spare ? (bus.cfg_wdata_i & 7'b111_0_0_1_1) : bus.cfg_wdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumPads; i++) cfg_q[i] <= CfgRst;
            gnt_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            gnt_q <= bus.cfg_req_i;
            err_q <= bus.cfg_req_i && !addr_ok;
            if (bus.cfg_req_i && addr_ok) cfg_q[bus.cfg_addr_i] <= wdata_eff;
        end
    end

    assign bus.cfg_gnt_o = gnt_q;
    assign bus.cfg_err_o = err_q;

    for (genvar i = 0; i < NumPads; i++) begin : g_pad
        logic [6:0] pin_cfg;
        assign pin_cfg     = cfg_vis ? cfg_q[i] : CfgRst;
        assign drv2[i]     = pin_cfg[6];
        assign drv1[i]     = pin_cfg[5];
        assign drv0[i]     = pin_cfg[4];
        assign pd[i]       = pin_cfg[3] | SpareMask[i];
        assign puq[i]      = ~pin_cfg[2];
        assign prg_slew[i] = pin_cfg[1];
        assign ppen[i]     = pin_cfg[0];
    end

    logic [NumPads-1:0] core_out, core_oe;
    assign core_out = NumPads'(bus.io_out_i);
    assign core_oe  = NumPads'(bus.io_oe_i);

    assign dq            = active ? core_out : '0;
    assign enq           = active ? (~core_oe | SpareMask) : '1;
    assign enabq         = {NumPads{rx_off}};
    assign pwrup_pull_en = {NumPads{pull_on}};
    assign pwrupzhl      = {NumPads{hold_zhl}};

    logic [NumIo-1:0] sync_src, sync1_q, sync2_q;
`ifdef PAD_BANK_LOOPBACK_EN
    assign sync_src = (lpbk_i && active) ? bus.io_out_i : outi[NumIo-1:0];
`else
    assign sync_src = outi[NumIo-1:0];
`endif

    // Receivers are off while enabq is high, so the synchroniser is cleared rather than sampling.
    always_ff @(posedge clk_i) begin
        if (rst_i || rx_off) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync_src;
            sync2_q <= sync1_q;
        end
    end

    assign bus.io_in_o = sync2_q;

    if (NumPads > NumIo) begin : g_spare_rx
        logic unused_spare_rx;
        assign unused_spare_rx = ^outi[NumPads-1:NumIo];
    end
endmodule

// File: tb/tb_pad_bank_ctrl.sv
`timescale 1ns/1ps
// Randomised bench for pad_bank_ctrl against a cycle-count / register-array model of the bank.
module tb_pad_bank_ctrl;
    localparam int NP = 72;
    localparam int NI = 71;
    localparam int PW = 16;
    localparam int ST = 4;
    localparam int AW = 7;
    localparam logic [6:0] DEF = 7'b001_0_0_0_0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pad_bank_ctrl_if #(.NumPads(NP), .NumIo(NI)) bus ();

    logic          ready;
    logic [NP-1:0] dq, enq, enabq, outi, drv0, drv1, drv2, pd, puq, slew, ppen, pull, zhl;
`ifdef PAD_BANK_LOOPBACK_EN
    logic          lpbk;
`endif

    pad_bank_ctrl #(.NumPads(NP), .NumIo(NI), .PwrupCycles(PW), .SettleCycles(ST)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef PAD_BANK_LOOPBACK_EN
        .lpbk_i        (lpbk),
`endif
        .bus           (bus),
        .ready_o       (ready),
        .dq            (dq),
        .enq           (enq),
        .enabq         (enabq),
        .outi          (outi),
        .drv0          (drv0),
        .drv1          (drv1),
        .drv2          (drv2),
        .pd            (pd),
        .puq           (puq),
        .prg_slew      (slew),
        .ppen          (ppen),
        .pwrup_pull_en (pull),
        .pwrupzhl      (zhl)
    );

    // Model: m = clock edges since the last reset edge; phase follows from m alone.
    int            m;
    logic [6:0]    mcfg [NP];
    logic          e_gnt, e_err;
    logic [NI-1:0] h1, h2;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int phase_of(input int cyc);
        if (cyc < PW) return 0;
        if (cyc == PW) return 1;
        if (cyc <= PW + ST) return 2;
        return 3;
    endfunction

    function automatic logic [NP-1:0] rand_np();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[NP-1:0];
    endfunction

    task automatic model_edge();
        int            ph;
        int            a;
        logic [NI-1:0] src;
        ph = phase_of(m);
        if (rst) begin
            m = 0;
            for (int i = 0; i < NP; i++) mcfg[i] = DEF;
            e_gnt = 1'b0;
            e_err = 1'b0;
            h1 = '0;
            h2 = '0;
        end else begin
            a = int'(bus.cfg_addr_i);
            e_gnt = bus.cfg_req_i;
            e_err = bus.cfg_req_i && (a >= NP);
            if (bus.cfg_req_i && a < NP)
                mcfg[a] = (a >= NI) ? {bus.cfg_wdata_i[6:4], 2'b00, bus.cfg_wdata_i[1:0]}
                                    : bus.cfg_wdata_i;
            src = outi[NI-1:0];
`ifdef PAD_BANK_LOOPBACK_EN
            if (lpbk && ph == 3) src = bus.io_out_i;
`endif
            if (ph <= 1) begin
                h1 = '0;
                h2 = '0;
            end else begin
                h2 = h1;
                h1 = src;
            end
            if (m < 100000) m++;
        end
    endtask

    task automatic check_all();
        int            ph;
        logic [6:0]    c;
        logic [NP-1:0] co, coe, x_dq, x_enq, x_d0, x_d1, x_d2, x_pd, x_puq, x_sl, x_pp;
        ph  = phase_of(m);
        co  = NP'(bus.io_out_i);
        coe = NP'(bus.io_oe_i);
        for (int i = 0; i < NP; i++) begin
            c = (ph == 0) ? DEF : mcfg[i];
            x_d0[i]  = c[4];
            x_d1[i]  = c[5];
            x_d2[i]  = c[6];
            x_pd[i]  = (i >= NI) ? 1'b1 : c[3];
            x_puq[i] = ~c[2];
            x_sl[i]  = c[1];
            x_pp[i]  = c[0];
            x_dq[i]  = (ph == 3 && i < NI) ? co[i] : 1'b0;
            x_enq[i] = (ph == 3 && i < NI) ? ~coe[i] : 1'b1;
        end
        check_eq("ready", NP'(ready), NP'(ph == 3));
        check_eq("pwrupzhl", zhl, (ph == 0) ? '1 : '0);
        check_eq("pwrup_pull_en", pull, (ph <= 1) ? '1 : '0);
        check_eq("enabq", enabq, (ph <= 1) ? '1 : '0);
        check_eq("dq", dq, x_dq);
        check_eq("enq", enq, x_enq);
        check_eq("drv0", drv0, x_d0);
        check_eq("drv1", drv1, x_d1);
        check_eq("drv2", drv2, x_d2);
        check_eq("pd", pd, x_pd);
        check_eq("puq", puq, x_puq);
        check_eq("prg_slew", slew, x_sl);
        check_eq("ppen", ppen, x_pp);
        check_eq("io_in", NP'(bus.io_in_o), NP'(h2));
        check_eq("cfg_gnt", NP'(bus.cfg_gnt_o), NP'(e_gnt));
        check_eq("cfg_err", NP'(bus.cfg_err_o), NP'(e_err));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    task automatic drive_rand(input int req_pct);
        bus.io_out_i   = NI'(rand_np());
        bus.io_oe_i    = NI'(rand_np());
        outi           = rand_np();
        bus.cfg_req_i  = ($urandom_range(99) < req_pct);
        bus.cfg_addr_i = ($urandom_range(3) == 0) ? AW'($urandom_range(127)) : AW'($urandom_range(NP - 1));
        bus.cfg_wdata_i = 7'($urandom);
`ifdef PAD_BANK_LOOPBACK_EN
        lpbk = 1'($urandom_range(1));
`endif
    endtask

    initial begin
        int first_rdy;
        rst = 1'b1;
        drive_rand(0);
        m = 0;
        tick();
        tick();
        rst = 1'b0;

        // Power-up sequence with a write in PWRUP_HOLD and one landing on the CFG_APPLY edge.
        first_rdy = -1;
        for (int j = 1; j <= 30; j++) begin
            drive_rand(0);
            if (m == 3) begin
                bus.cfg_req_i = 1'b1; bus.cfg_addr_i = AW'(3); bus.cfg_wdata_i = 7'b110_1_0_1_1;
            end
            if (m == PW - 1) begin
                bus.cfg_req_i = 1'b1; bus.cfg_addr_i = AW'(4); bus.cfg_wdata_i = 7'b011_0_1_0_1;
            end
            settle_check();
            tick();
            if (m == PW) begin
                check_eq("pad3_drv_apply", NP'({drv2[3], drv1[3], drv0[3]}), NP'(3'b110));
                check_eq("pad4_ppen_apply", NP'(ppen[4]), NP'(1'b1));
                check_eq("pad4_puq_apply", NP'(puq[4]), NP'(1'b0));
            end
            if (ready && first_rdy < 0) first_rdy = j;
        end
        // ready rises on the 21st edge after release, i.e. the 22nd cycle counting the release cycle.
        check_eq("ready_latency", NP'(first_rdy), NP'(PW + ST + 1));

        drive_rand(0);
        bus.io_oe_i[5] = 1'b1;
        bus.io_out_i[5] = 1'b1;
        settle_check();
        check_eq("dq5", NP'(dq[5]), NP'(1'b1));
        check_eq("enq5", NP'(enq[5]), NP'(1'b0));
        tick();

        drive_rand(0);
        bus.cfg_req_i = 1'b1; bus.cfg_addr_i = AW'(10); bus.cfg_wdata_i = 7'b101_0_1_1_1;
        settle_check();
        tick();
        check_eq("gnt_addr10", NP'(bus.cfg_gnt_o), NP'(1'b1));
        check_eq("pad10_drv", NP'({drv2[10], drv1[10], drv0[10]}), NP'(3'b101));
        check_eq("pad10_puq", NP'(puq[10]), NP'(1'b0));
        check_eq("pad10_slew_ppen", NP'({slew[10], ppen[10]}), NP'(2'b11));

        drive_rand(0);
        bus.cfg_req_i = 1'b1; bus.cfg_addr_i = AW'(72); bus.cfg_wdata_i = 7'h7f;
        settle_check();
        tick();
        check_eq("err_addr72", NP'({bus.cfg_err_o, bus.cfg_gnt_o}), NP'(2'b11));
        drive_rand(0);
        settle_check();
        tick();

        for (int k = 0; k < 300; k++) begin
            drive_rand(60);
            settle_check();
            tick();
            check_eq("pad71_enq_pd", NP'({enq[71], pd[71]}), NP'(2'b11));
        end

        for (int k = 0; k < 8; k++) begin
            drive_rand(0);
`ifdef PAD_BANK_LOOPBACK_EN
            lpbk = 1'b0;
`endif
            outi[7] = k[0];
            settle_check();
            tick();
        end

`ifdef PAD_BANK_LOOPBACK_EN
        for (int k = 0; k < 20; k++) begin
            drive_rand(0);
            lpbk = 1'b1;
            outi = '0;
            settle_check();
            tick();
        end
`endif

        rst = 1'b1;
        drive_rand(50);
        settle_check();
        tick();
        check_eq("rst_ready", NP'(ready), '0);
        check_eq("rst_enq", enq, '1);
        rst = 1'b0;

        for (int k = 0; k < 200; k++) begin
            drive_rand(40);
            settle_check();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_bank_ctrl.md
Name: pad_bank_ctrl

Overview:
Parametrised pad-bank controller between the core I/O bus (io_out/io_oe/io_in) and a bank of NumPads bidirectional pad cells.
- Replaces the fixed 71-signal to 72-pad crossbar.
- Adds a power-up sequencer, per-pad runtime drive/pull/slew configuration over a req/gnt port, and 2-flop input synchronisation.
- Pads with index >= NumIo are spares: tristated and pulled down.

Parameters:
NumPads, 72, number of pad cells in the bank
NumIo, 71, core I/O signals mapped 1:1 onto pads 0..NumIo-1 (NumIo <= NumPads)
PwrupCycles, 16, cycles in PWRUP_HOLD (>= 1)
SettleCycles, 4, cycles in SETTLE (>= 1)

Ports:
clk_i  in  1  bank clock
rst_i  in  1  synchronous, active-high reset
io_out_i  in  NumIo  core output data
io_oe_i  in  NumIo  core output enable, 1 = drive
io_in_o  out  NumIo  synchronised pad input to core
cfg_req_i  in  1  config write request
cfg_addr_i  in  $clog2(NumPads)  pad index
cfg_wdata_i  in  7  {drv[2:0], pd, pu, slew, ppen}
cfg_gnt_o  out  1  config write accepted
cfg_err_o  out  1  pulse: cfg_addr_i >= NumPads
ready_o  out  1  sequencer in ACTIVE
dq  out  NumPads  pad output data
enq  out  NumPads  pad output enable, active low
enabq  out  NumPads  pad receiver enable, active low
outi  in  NumPads  pad receive data
drv0, drv1, drv2  out  NumPads  drive-strength bits 0..2
pd  out  NumPads  pulldown enable
puq  out  NumPads  pullup enable, active low
prg_slew  out  NumPads  slew select
ppen  out  NumPads  push-pull enable
pwrup_pull_en  out  NumPads  power-up pull enable
pwrupzhl  out  NumPads  power-up hi-Z hold

Behaviour:
- Reset and clocking: one clock, clk_i. rst_i is synchronous and active-high and is sampled on the clk_i edge.
- Reset values:
  - Sequencer to PWRUP_HOLD; counter 0; ready_o 0.
  - Every config register to 7'b001_0_0_0_0 (drv=1, no pulls, slow slew, ppen 0).
  - Sync flops 0; io_in_o 0; cfg_gnt_o 0; cfg_err_o 0.
- Sequencer FSM (one state register):
  - PWRUP_HOLD: pwrupzhl=1, pwrup_pull_en=1, enq=1, enabq=1 on all pads. Lasts exactly PwrupCycles cycles, then CFG_APPLY.
  - CFG_APPLY: one cycle. pwrupzhl drops to 0. Config registers now drive drv*/pd/puq/prg_slew/ppen; enq stays 1. Next state SETTLE.
  - SETTLE: SettleCycles cycles. pwrup_pull_en=0, enabq=0, enq=1. Next state ACTIVE.
  - ACTIVE: ready_o=1. For i < NumIo: dq[i]=io_out_i[i], enq[i]=~io_oe_i[i], combinational from core. Spare pads: dq=0, enq=1, pd=1 forced.
- Outside ACTIVE, dq=0 and enq=1 regardless of core inputs.
- rst_i asserted in any state returns to PWRUP_HOLD on the next edge; config registers reset as well.
- Config port:
  - cfg_gnt_o is registered: asserted the cycle after cfg_req_i is sampled high. The write lands on the same edge that sets cfg_gnt_o.
  - Back-to-back requests are accepted one per cycle.
  - Writes are accepted in all states. During PWRUP_HOLD they are stored but not visible on pad pins until CFG_APPLY.
  - Out-of-range address: no register is written; cfg_gnt_o and cfg_err_o both pulse 1 cycle.
  - Writes to spare pads store drv/slew/ppen only; pd stays forced 1.
- Input path: outi passes through a 2-flop synchroniser into io_in_o, so io_in_o[i] lags outi[i] by 2 cycles. The synchroniser is held 0 while enabq=1.
- Simultaneous events: a cfg write and the CFG_APPLY transition in the same cycle means the new value is visible from the next cycle.

Optional Feature:
PAD_BANK_LOOPBACK_EN
- Defined:
  - Adds input port lpbk_i (1 bit).
  - When lpbk_i=1 in ACTIVE, the synchroniser input for pad i < NumIo is io_out_i[i] instead of outi[i]; same 2-cycle latency.
  - Pad pins are unchanged.
- Undefined: port absent; synchroniser always sources outi.

Test Plan:
- Release rst_i -> pwrupzhl all 1 for exactly 16 cycles, then 1 cycle CFG_APPLY, then 4 cycles SETTLE; ready_o=1 on cycle 22 after reset release.
- In ACTIVE, io_oe_i[5]=1, io_out_i[5]=1 -> same cycle dq[5]=1, enq[5]=0. Pad 71 stays enq=1, pd=1 throughout.
- Write addr 10, data 7'b101_0_1_1_1 in ACTIVE -> cfg_gnt_o next cycle; then drv2..0=101, puq[10]=0, prg_slew[10]=1, ppen[10]=1. Write addr 72 -> cfg_err_o pulse, no register changes.
- Write addr 3 during PWRUP_HOLD -> pad pins keep reset value until CFG_APPLY, then show the new value.
- Toggle outi[7] in ACTIVE -> io_in_o[7] follows 2 cycles later. Assert rst_i mid-ACTIVE -> next edge ready_o=0, enq all 1, config back to default.
- With PAD_BANK_LOOPBACK_EN defined, lpbk_i=1 and outi forced 0 -> io_in_o[20] tracks io_out_i[20] with 2-cycle lag.
